// File: rtl/mips_pkg.sv
// Shared constants and helpers for the EX->MEM pipeline register.
//   REG_RA       : register written by jal/jalr
//   LINK_OFS     : link address offset from the instruction PC
//   TNEW_*_W     : Tnew field widths in the EX and MEM stages
//   BUBBLE_*     : field values loaded on flush
//   tnew_to_mem  : Tnew countdown from EX to MEM
package mips_pkg;

    localparam logic [4:0] REG_RA     = 5'd31;
    localparam int         LINK_OFS   = 8;

    localparam int         TNEW_EX_W  = 2;
    localparam int         TNEW_MEM_W = 1;

    localparam logic        BUBBLE_VALID = 1'b0;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [4:0]  BUBBLE_RD    = 5'd0;
    localparam logic [TNEW_MEM_W-1:0] BUBBLE_TNEW = '0;

    // One stage of countdown. The code 3 never appears from a legal
    // decoder; it is treated like 2 so the MEM stage never sees an
    // out-of-range value.
    function automatic logic [TNEW_MEM_W-1:0] tnew_to_mem(input logic [TNEW_EX_W-1:0] t);
        logic [TNEW_MEM_W-1:0] r;
        case (t)
            2'd0:    r = 1'b0;
            2'd1:    r = 1'b0;
            2'd2:    r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX->MEM bundle interface.
//   master : upstream side (drives en/clr and the *_EX bundle, observes MEM outputs)
//   slave  : the pipeline register (consumes *_EX, drives *_MEM and stall_cnt)
interface ex_mem_reg_if #(
    parameter int DW  = 32,
    parameter int SCW = 16
);
    import mips_pkg::*;

    logic                  en;
    logic                  clr;

    logic                  valid_EX;
    logic [31:0]           instr_EX;
    logic [DW-1:0]         pc_EX;
    logic [DW-1:0]         alu_EX;
    logic [DW-1:0]         rtdata_EX;
    logic [4:0]            rd_EX;
    logic                  link_EX;
    logic [TNEW_EX_W-1:0]  Tnew_EX;

    logic                  valid_MEM;
    logic [31:0]           instr_MEM;
    logic [DW-1:0]         pc_MEM;
    logic [DW-1:0]         alu_MEM;
    logic [DW-1:0]         rtdata_MEM;
    logic [4:0]            rd_MEM;
    logic [TNEW_MEM_W-1:0] Tnew_MEM;
    logic [DW-1:0]         fwd_data_MEM;
    logic                  fwd_ok_MEM;
    logic [SCW-1:0]        stall_cnt;

    modport master (
        output en, clr,
        output valid_EX, instr_EX, pc_EX, alu_EX, rtdata_EX, rd_EX, link_EX, Tnew_EX,
        input  valid_MEM, instr_MEM, pc_MEM, alu_MEM, rtdata_MEM, rd_MEM, Tnew_MEM,
        input  fwd_data_MEM, fwd_ok_MEM, stall_cnt
    );

    modport slave (
        input  en, clr,
        input  valid_EX, instr_EX, pc_EX, alu_EX, rtdata_EX, rd_EX, link_EX, Tnew_EX,
        output valid_MEM, instr_MEM, pc_MEM, alu_MEM, rtdata_MEM, rd_MEM, Tnew_MEM,
        output fwd_data_MEM, fwd_ok_MEM, stall_cnt
    );

endinterface

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   clr : synchronous clear (wins over inc)
//   inc : add one, unless already at all-ones
//   cnt : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register of the 5-stage MIPS core.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : EX bundle in, MEM bundle out, en (advance) / clr (flush),
//           forwarding outputs (rd_MEM, Tnew_MEM, fwd_data_MEM, fwd_ok_MEM)
//           and the saturating held-cycle counter stall_cnt.
// Edge priority: reset > flush > advance > hold.
module ex_mem_reg
    import mips_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SCW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_reg_if.slave  bus
);

    logic stall_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.valid_MEM    <= 1'b0;
            bus.instr_MEM    <= '0;
            bus.pc_MEM       <= '0;
            bus.alu_MEM      <= '0;
            bus.rtdata_MEM   <= '0;
            bus.rd_MEM       <= '0;
            bus.Tnew_MEM     <= '0;
            bus.fwd_data_MEM <= '0;
        end else if (bus.clr) begin
            bus.valid_MEM    <= BUBBLE_VALID;
            bus.instr_MEM    <= BUBBLE_INSTR;
            bus.pc_MEM       <= '0;
            bus.alu_MEM      <= '0;
            bus.rtdata_MEM   <= '0;
            bus.rd_MEM       <= BUBBLE_RD;
            bus.Tnew_MEM     <= BUBBLE_TNEW;
            bus.fwd_data_MEM <= '0;
        end else if (bus.en) begin
            bus.valid_MEM    <= bus.valid_EX;
            bus.instr_MEM    <= bus.instr_EX;
            bus.pc_MEM       <= bus.pc_EX;
            bus.alu_MEM      <= bus.alu_EX;
            bus.rtdata_MEM   <= bus.rtdata_EX;
            // A non-valid slot never claims a destination, so forwarding
            // cannot match on it even though the debug fields are kept.
            bus.rd_MEM       <= !bus.valid_EX ? BUBBLE_RD
                              : (bus.link_EX ? REG_RA : bus.rd_EX);
            bus.Tnew_MEM     <= tnew_to_mem(bus.Tnew_EX);
            // Link address is formed here so MEM forwards a registered value.
            bus.fwd_data_MEM <= bus.link_EX ? (bus.pc_EX + DW'(LINK_OFS)) : bus.alu_EX;
        end
    end

    assign bus.fwd_ok_MEM = (bus.rd_MEM != 5'd0) && (bus.Tnew_MEM == '0);

    // Only true hold edges with a live instruction count as stall cycles.
    assign stall_inc = !bus.clr && !bus.en && bus.valid_MEM;

    sat_counter #(
        .W (SCW)
    ) u_stall_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (stall_inc),
        .cnt (bus.stall_cnt)
    );

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;
    localparam int DW  = 32;
    localparam int SCW = 4;
    localparam int CNT_MAX = (1 << SCW) - 1;

    logic clk;
    logic rst_n;

    ex_mem_reg_if #(.DW(DW), .SCW(SCW)) ifc ();

    ex_mem_reg #(.DW(DW), .SCW(SCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of what MEM should hold after each edge.
    logic          m_valid;
    logic [31:0]   m_instr;
    logic [DW-1:0] m_pc, m_alu, m_rt, m_fwd;
    int            m_rd;
    int            m_tnew;
    int            m_cnt;

    task automatic tick();
        longint unsigned s;
        int t;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_alu = 0; m_rt = 0;
            m_rd = 0; m_tnew = 0; m_fwd = 0; m_cnt = 0;
        end else if (ifc.clr) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_alu = 0; m_rt = 0;
            m_rd = 0; m_tnew = 0; m_fwd = 0;
        end else if (ifc.en) begin
            m_valid = ifc.valid_EX;
            m_instr = ifc.instr_EX;
            m_pc    = ifc.pc_EX;
            m_alu   = ifc.alu_EX;
            m_rt    = ifc.rtdata_EX;
            if (!ifc.valid_EX)     m_rd = 0;
            else if (ifc.link_EX)  m_rd = 31;
            else                   m_rd = int'(ifc.rd_EX);
            t = int'(ifc.Tnew_EX);
            m_tnew = (t == 0) ? 0 : ((t == 3) ? 1 : t - 1);
            if (ifc.link_EX) begin
                s = (longint'(ifc.pc_EX) + 8) % 64'h1_0000_0000;
                m_fwd = s[DW-1:0];
            end else begin
                m_fwd = ifc.alu_EX;
            end
        end else begin
            if (m_valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] ins, input logic [DW-1:0] pc,
                          input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                          input logic [4:0] rd, input logic lnk, input logic [1:0] tn);
        ifc.valid_EX = v; ifc.instr_EX = ins; ifc.pc_EX = pc; ifc.alu_EX = alu;
        ifc.rtdata_EX = rt; ifc.rd_EX = rd; ifc.link_EX = lnk; ifc.Tnew_EX = tn;
    endtask

    task automatic test_reset();
        rst_n = 0; ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h8D09_0004, 32'h0040_0010, 32'hDEAD_BEEF, 32'h1111_2222, 5'd9, 1, 2'd2);
        tick(); tick();
        total++;
        if ({ifc.valid_MEM, ifc.instr_MEM, ifc.pc_MEM, ifc.alu_MEM, ifc.rtdata_MEM,
             ifc.rd_MEM, ifc.Tnew_MEM, ifc.fwd_data_MEM} !== '0) begin
            bad++; $display("FAIL reset_fields: got instr=%h pc=%h alu=%h rd=%0d want all 0",
                            ifc.instr_MEM, ifc.pc_MEM, ifc.alu_MEM, ifc.rd_MEM);
        end
        total++;
        if (ifc.fwd_ok_MEM !== 1'b0 || ifc.stall_cnt !== 4'd0) begin
            bad++; $display("FAIL reset_ok_cnt: got fwd_ok=%b cnt=%0d want 0/0",
                            ifc.fwd_ok_MEM, ifc.stall_cnt);
        end
        rst_n = 1;
    endtask

    task automatic test_alu_advance();
        ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h0109_4021, 32'h0040_0000, 32'h0000_1234, 32'h0, 5'd8, 0, 2'd1);
        tick();
        total++;
        if (ifc.rd_MEM !== 5'd8 || ifc.Tnew_MEM !== 1'b0 || ifc.fwd_data_MEM !== 32'h1234
            || ifc.fwd_ok_MEM !== 1'b1 || ifc.valid_MEM !== 1'b1) begin
            bad++; $display("FAIL alu_advance: got rd=%0d tnew=%0d fwd=%h ok=%b want 8/0/1234/1",
                            ifc.rd_MEM, ifc.Tnew_MEM, ifc.fwd_data_MEM, ifc.fwd_ok_MEM);
        end
    endtask

    task automatic test_load_hold();
        ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h8D09_0000, 32'h0040_0004, 32'h1000_0000, 32'h0, 5'd9, 0, 2'd2);
        tick();
        total++;
        if (ifc.Tnew_MEM !== 1'b1 || ifc.fwd_ok_MEM !== 1'b0 || ifc.rd_MEM !== 5'd9) begin
            bad++; $display("FAIL load_capture: got tnew=%0d ok=%b rd=%0d want 1/0/9",
                            ifc.Tnew_MEM, ifc.fwd_ok_MEM, ifc.rd_MEM);
        end
        ifc.en = 0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 2'd0);
            tick();
        end
        total++;
        if (ifc.Tnew_MEM !== 1'b1 || ifc.stall_cnt !== 4'd3 || ifc.alu_MEM !== 32'h1000_0000
            || ifc.rd_MEM !== 5'd9) begin
            bad++; $display("FAIL load_hold: got tnew=%0d cnt=%0d alu=%h rd=%0d want 1/3/10000000/9",
                            ifc.Tnew_MEM, ifc.stall_cnt, ifc.alu_MEM, ifc.rd_MEM);
        end
    endtask

    task automatic test_link_wrap();
        ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h0C00_0000, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0, 5'd0, 1, 2'd0);
        tick();
        total++;
        if (ifc.rd_MEM !== 5'd31 || ifc.fwd_data_MEM !== 32'h0000_0004 || ifc.fwd_ok_MEM !== 1'b1
            || ifc.alu_MEM !== 32'h5555_5555) begin
            bad++; $display("FAIL link_wrap: got rd=%0d fwd=%h ok=%b want 31/00000004/1",
                            ifc.rd_MEM, ifc.fwd_data_MEM, ifc.fwd_ok_MEM);
        end
        total++;
        if (ifc.stall_cnt !== 4'd3) begin
            bad++; $display("FAIL link_cnt: got %0d want 3", ifc.stall_cnt);
        end
    endtask

    task automatic test_flush();
        ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h8D0A_0000, 32'h0040_0020, 32'h2000_0000, 32'h0, 5'd10, 0, 2'd2);
        tick();
        ifc.en = 0;
        tick();
        ifc.clr = 1;
        tick();
        ifc.clr = 0;
        total++;
        if (ifc.valid_MEM !== 1'b0 || ifc.rd_MEM !== 5'd0 || ifc.Tnew_MEM !== 1'b0
            || ifc.instr_MEM !== 32'h0 || ifc.fwd_data_MEM !== 32'h0 || ifc.fwd_ok_MEM !== 1'b0) begin
            bad++; $display("FAIL flush_bubble: got v=%b rd=%0d tnew=%0d instr=%h want 0/0/0/0",
                            ifc.valid_MEM, ifc.rd_MEM, ifc.Tnew_MEM, ifc.instr_MEM);
        end
        total++;
        if (ifc.stall_cnt !== 4'd4) begin
            bad++; $display("FAIL flush_cnt: got %0d want 4", ifc.stall_cnt);
        end
        // holding a bubble must not count
        tick(); tick();
        total++;
        if (ifc.stall_cnt !== 4'd4) begin
            bad++; $display("FAIL bubble_hold_cnt: got %0d want 4", ifc.stall_cnt);
        end
    endtask

    task automatic test_saturation();
        ifc.en = 1; ifc.clr = 0;
        set_ex(1, 32'h0000_0000, 32'h0040_0030, 32'h7, 32'h0, 5'd3, 0, 2'd1);
        tick();
        ifc.en = 0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (ifc.stall_cnt !== 4'd15) begin
            bad++; $display("FAIL saturate: got %0d want 15", ifc.stall_cnt);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        total++;
        if (ifc.stall_cnt !== 4'd0 || ifc.valid_MEM !== 1'b0) begin
            bad++; $display("FAIL reset_mid_stall: got cnt=%0d v=%b want 0/0",
                            ifc.stall_cnt, ifc.valid_MEM);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 99) >= 3);
            ifc.clr = ($urandom_range(0, 99) < 10);
            ifc.en  = ($urandom_range(0, 99) < 55);
            set_ex(1'($urandom_range(0, 9) != 0), $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom));
            if (i % 50 == 7) ifc.pc_EX = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            tick();
            total++;
            if (ifc.valid_MEM !== m_valid || ifc.instr_MEM !== m_instr || ifc.pc_MEM !== m_pc
                || ifc.alu_MEM !== m_alu || ifc.rtdata_MEM !== m_rt
                || int'(ifc.rd_MEM) != m_rd || int'(ifc.Tnew_MEM) != m_tnew
                || ifc.fwd_data_MEM !== m_fwd) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL rand_fields[%0d]: got v=%b rd=%0d tnew=%0d fwd=%h want v=%b rd=%0d tnew=%0d fwd=%h",
                             i, ifc.valid_MEM, ifc.rd_MEM, ifc.Tnew_MEM, ifc.fwd_data_MEM,
                             m_valid, m_rd, m_tnew, m_fwd);
            end
            total++;
            if (ifc.fwd_ok_MEM !== ((m_rd != 0) && (m_tnew == 0)) || int'(ifc.stall_cnt) != m_cnt) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL rand_ok_cnt[%0d]: got ok=%b cnt=%0d want ok=%b cnt=%0d",
                             i, ifc.fwd_ok_MEM, ifc.stall_cnt,
                             (m_rd != 0) && (m_tnew == 0), m_cnt);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; ifc.en = 0; ifc.clr = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_advance();
        test_load_hold();
        test_link_wrap();
        test_flush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX→MEM pipeline register of the 5-stage MIPS core.
- Captures the EX-stage result bundle each advancing cycle and presents it to the MEM stage.
- Sources rd_MEM and Tnew_MEM for the forwarding unit, plus the MEM-stage forward data word.
- Supports hold (stall), bubble insertion (flush), Tnew countdown and a saturating stall-cycle counter.

Parameters:
- DW, 32, datapath width (PC, ALU result, store data).
- SCW, 16, stall-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  1 = advance (capture EX bundle); 0 = hold current contents
- clr  in  1  1 = load bubble at next edge (flush)
- valid_EX  in  1  EX holds a real instruction
- instr_EX  in  32  instruction word
- pc_EX  in  DW  instruction PC
- alu_EX  in  DW  ALU result
- rtdata_EX  in  DW  store data, already forwarded
- rd_EX  in  5  destination register; 0 = no write
- link_EX  in  1  jal/jalr: write pc+8 instead of ALU result
- Tnew_EX  in  2  cycles until result is available, counted from EX (0..2)
- valid_MEM  out  1
- instr_MEM  out  32
- pc_MEM  out  DW
- alu_MEM  out  DW
- rtdata_MEM  out  DW
- rd_MEM  out  5
- Tnew_MEM  out  1
- fwd_data_MEM  out  DW  value the forwarding mux takes from MEM
- fwd_ok_MEM  out  1  rd_MEM!=0 and Tnew_MEM==0 (MEM value usable now)
- stall_cnt  out  SCW  count of held cycles with valid_MEM=1

Behaviour:
- **Clocking and reset:** all state updates on the rising edge of clk. One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- **Edge priority:** rst_n=0 > clr=1 > en=1 > hold.
- **Reset:** every output goes to 0 at the edge: valid, instr, pc, alu, rtdata, rd, Tnew, fwd_data, fwd_ok, stall_cnt.
- **clr=1 (regardless of en):** bubble loaded. valid=0, instr=0, rd=0, Tnew=0, data fields=0. stall_cnt unchanged.
- **en=1, clr=0:** capture the EX bundle, with these rules:
  - rd_MEM = valid_EX ? (link_EX ? 5'd31 : rd_EX) : 0.
  - Tnew_MEM = (Tnew_EX==0) ? 0 : Tnew_EX-1. Tnew_EX=3 is illegal; load 1.
  - fwd_data_MEM = link_EX ? pc_EX+8 (mod 2^DW, wraps) : alu_EX. Computed and registered at capture, not combinationally afterwards.
  - All other fields copied verbatim.
- **en=0, clr=0 (hold):** all pipeline fields keep their values, including Tnew. Tnew does not decrement while stalled; the MEM stage is frozen.
- **stall_cnt:** increments by 1 on a hold edge when valid_MEM=1. Saturates at 2^SCW-1. Cleared only by reset.
- **fwd_ok_MEM:** combinational from registered rd_MEM and Tnew_MEM. Never 1 when rd_MEM=0.
- **Latency:** exactly 1 cycle from EX inputs to MEM outputs on an advancing edge.
- **valid_EX=0 with en=1:** the register fills as a bubble-equivalent, but instr, pc and data are still copied for debug visibility; rd forced to 0.
- **Reset mid-stall:** reset wins; stall_cnt returns to 0.
- **Forwarding-unit contract:** consumers must ignore fwd_data_MEM when fwd_ok_MEM=0 (load in MEM).

Decomposition:
- Shared package (mips_pkg):
  - constant REG_RA = 5'd31
  - constant LINK_OFS = 8
  - Tnew/Tuse width localparams (TNEW_EX_W=2, TNEW_MEM_W=1)
  - bubble-value constants
- One natural sub-module: sat_counter (SCW-wide increment-enable, saturating, synchronous clear). Used for stall_cnt.
- Everything else stays flat in ex_mem_reg.

Test Plan:
1. **Reset:** rst_n=0 for 2 cycles, inputs non-zero → all outputs 0, fwd_ok_MEM=0.
2. **ALU advance:** en=1, addu, rd_EX=8, alu_EX=0x0000_1234, Tnew_EX=1 → next cycle rd_MEM=8, Tnew_MEM=0, fwd_data_MEM=0x1234, fwd_ok_MEM=1.
3. **Load:** lw, rd_EX=9, Tnew_EX=2 → Tnew_MEM=1, fwd_ok_MEM=0. Hold en=0 for 3 cycles → Tnew_MEM stays 1, stall_cnt=3.
4. **Link:** jal at pc_EX=0xFFFF_FFFC, link_EX=1, rd_EX=0 → rd_MEM=31, fwd_data_MEM=0x0000_0004 (wrap).
5. **Flush:** clr=1 and en=0 in the same cycle while holding a valid lw → valid_MEM=0, rd_MEM=0, Tnew_MEM=0, stall_cnt unchanged.
6. **Saturation:** SCW=4, hold 20 cycles with valid_MEM=1 → stall_cnt=15. Then rst_n=0 during hold → stall_cnt=0 next edge.
